// File: rtl/mult_div_unit.sv
`default_nettype none
// ============================================================================
// Module      : mult_div_unit
// Description : Iterative shift-add multiplier / restoring divider that owns
//               the architectural HI/LO registers (MULT, MULTU, DIV, DIVU).
// Revision    : 1.0 - initial release
// ============================================================================
module mult_div_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] operand_a,
    input  logic [WIDTH-1:0] operand_b,
    input  logic             mthi,
    input  logic             mtlo,
    input  logic [WIDTH-1:0] hi_wdata,
    output logic             busy,
    output logic             done,
    output logic             div_by_zero,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0]      c_countInit = CW'(WIDTH);
    localparam logic [CW-1:0]      c_countOne  = CW'(1);
    localparam logic [WIDTH-1:0]   c_zeroW     = '0;
    localparam logic [2*WIDTH-1:0] c_zero2W    = '0;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2
    } state_t;

    state_t r_state;
    state_t w_nextState;

    logic [CW-1:0]      r_count;
    logic               r_isDiv;
    logic               r_divZero;
    logic               r_resNeg;
    logic               r_remNeg;
    logic [WIDTH-1:0]   r_a;        // dividend magnitude, becomes the quotient
    logic [WIDTH-1:0]   r_b;        // multiplier (shifted out) or divisor
    logic [2*WIDTH-1:0] r_mcand;
    logic [2*WIDTH-1:0] r_acc;      // product, or partial remainder in low half
    logic [WIDTH-1:0]   r_hi;
    logic [WIDTH-1:0]   r_lo;
    logic               r_done;
    logic               r_divByZero;

    logic               w_negA;
    logic               w_negB;
    logic [WIDTH-1:0]   w_absA;
    logic [WIDTH-1:0]   w_absB;
    logic [WIDTH:0]     w_shift;
    logic [WIDTH-1:0]   w_diff;
    logic               w_qBit;
    logic [WIDTH-1:0]   w_remNext;
    logic [2*WIDTH-1:0] w_prodFix;
    logic [WIDTH-1:0]   w_quotFix;
    logic [WIDTH-1:0]   w_remFix;
    logic [WIDTH-1:0]   w_fixHi;
    logic [WIDTH-1:0]   w_fixLo;

    // Signed ops are the even opcodes (MULT, DIV)
    assign w_negA = ~op[0] & operand_a[WIDTH-1];
    assign w_negB = ~op[0] & operand_b[WIDTH-1];
    assign w_absA = w_negA ? (c_zeroW - operand_a) : operand_a;
    assign w_absB = w_negB ? (c_zeroW - operand_b) : operand_b;

    // Restoring step; the partial remainder stays below the divisor, so the
    // difference fits in WIDTH bits whenever the quotient bit is set.
    assign w_shift   = {r_acc[WIDTH-1:0], r_a[WIDTH-1]};
    assign w_qBit    = (w_shift >= {1'b0, r_b});
    assign w_diff    = w_shift[WIDTH-1:0] - r_b;
    assign w_remNext = w_qBit ? w_diff : w_shift[WIDTH-1:0];

    // A zero divisor leaves the dividend magnitude as remainder, so the
    // remainder-sign fix restores operand_a exactly.
    assign w_prodFix = r_resNeg ? (c_zero2W - r_acc) : r_acc;
    assign w_quotFix = r_divZero ? {WIDTH{1'b1}} : (r_resNeg ? (c_zeroW - r_a) : r_a);
    assign w_remFix  = r_remNeg ? (c_zeroW - r_acc[WIDTH-1:0]) : r_acc[WIDTH-1:0];
    assign w_fixHi   = r_isDiv ? w_remFix  : w_prodFix[2*WIDTH-1:WIDTH];
    assign w_fixLo   = r_isDiv ? w_quotFix : w_prodFix[WIDTH-1:0];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    always_comb begin
        w_nextState = r_state;
        case (r_state)
            IDLE:    if (start) w_nextState = CALC;
            CALC:    if (r_count == c_countOne) w_nextState = FIX;
            FIX:     w_nextState = IDLE;
            default: w_nextState = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_count     <= '0;
            r_isDiv     <= 1'b0;
            r_divZero   <= 1'b0;
            r_resNeg    <= 1'b0;
            r_remNeg    <= 1'b0;
            r_a         <= '0;
            r_b         <= '0;
            r_mcand     <= '0;
            r_acc       <= '0;
            r_hi        <= '0;
            r_lo        <= '0;
            r_done      <= 1'b0;
            r_divByZero <= 1'b0;
        end else begin
            r_done      <= 1'b0;
            r_divByZero <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_isDiv   <= op[1];
                        r_divZero <= op[1] & (operand_b == c_zeroW);
                        r_resNeg  <= w_negA ^ w_negB;
                        r_remNeg  <= w_negA & op[1];
                        r_a       <= w_absA;
                        r_b       <= w_absB;
                        r_mcand   <= {c_zeroW, w_absA};
                        r_acc     <= '0;
                        r_count   <= c_countInit;
                    end else begin
                        if (mthi) r_hi <= hi_wdata;
                        if (mtlo) r_lo <= hi_wdata;
                    end
                end
                CALC: begin
                    r_count <= r_count - c_countOne;
                    if (r_isDiv) begin
                        r_acc <= {c_zeroW, w_remNext};
                        r_a   <= {r_a[WIDTH-2:0], w_qBit};
                    end else begin
                        if (r_b[0]) r_acc <= r_acc + r_mcand;
                        r_mcand <= r_mcand << 1;
                        r_b     <= r_b >> 1;
                    end
                end
                FIX: begin
                    r_hi        <= w_fixHi;
                    r_lo        <= w_fixLo;
                    r_done      <= 1'b1;
                    r_divByZero <= r_divZero;
                end
                default: ;
            endcase
        end
    end

    assign busy        = (r_state != IDLE);
    assign done        = r_done;
    assign div_by_zero = r_divByZero;
    assign hi          = r_hi;
    assign lo          = r_lo;

endmodule
`default_nettype wire

// File: tb/tb_mult_div_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_mult_div_unit
// Description : Directed bench for mult_div_unit with a transaction-level
//               reference model checked every cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mult_div_unit;

    localparam int W = 32;
    localparam logic [1:0] OP_MULT = 2'b00, OP_MULTU = 2'b01, OP_DIV = 2'b10, OP_DIVU = 2'b11;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         start = 1'b0;
    logic [1:0]   op = 2'b00;
    logic [W-1:0] operand_a = '0;
    logic [W-1:0] operand_b = '0;
    logic         mthi = 1'b0;
    logic         mtlo = 1'b0;
    logic [W-1:0] hi_wdata = '0;
    logic         busy, done, div_by_zero;
    logic [W-1:0] hi, lo;

    int vectors = 0;
    int errors  = 0;
    bit chkEn   = 1'b0;

    mult_div_unit #(.WIDTH(W)) dut (
        .clk(clk), .reset(reset), .start(start), .op(op),
        .operand_a(operand_a), .operand_b(operand_b),
        .mthi(mthi), .mtlo(mtlo), .hi_wdata(hi_wdata),
        .busy(busy), .done(done), .div_by_zero(div_by_zero),
        .hi(hi), .lo(lo)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Architectural result {div_by_zero, hi, lo} from plain integer arithmetic
    function automatic logic [2*W:0] refResult(input logic [1:0] o, input logic [W-1:0] a,
                                               input logic [W-1:0] b);
        longint          sa, sb, q, rm;
        longint unsigned ua, ub, uq, urm;
        logic [63:0]     r;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = {32'h0, a};
        ub = {32'h0, b};
        r  = '0;
        case (o)
            OP_MULT:  r = sa * sb;
            OP_MULTU: r = ua * ub;
            default: begin
                if (b == 0) begin
                    r = {a, 32'hFFFF_FFFF};
                end else if (o == OP_DIV) begin
                    q  = sa / sb;
                    rm = sa % sb;
                    r  = {rm[31:0], q[31:0]};
                end else begin
                    uq  = ua / ub;
                    urm = ua % ub;
                    r   = {urm[31:0], uq[31:0]};
                end
            end
        endcase
        return {(o[1] && b == 0), r};
    endfunction

    // Transaction model: result appears WIDTH+1 edges after acceptance
    int           mCnt;
    logic [W-1:0] mHi, mLo, pHi, pLo;
    logic         mDone, mDbz, pDbz;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            mCnt <= 0; mHi <= '0; mLo <= '0; mDone <= 1'b0; mDbz <= 1'b0;
            pHi <= '0; pLo <= '0; pDbz <= 1'b0;
        end else begin
            mDone <= 1'b0;
            mDbz  <= 1'b0;
            if (mCnt > 0) begin
                if (mCnt == 1) begin
                    mHi <= pHi; mLo <= pLo; mDone <= 1'b1; mDbz <= pDbz;
                end
                mCnt <= mCnt - 1;
            end else if (start) begin
                {pDbz, pHi, pLo} <= refResult(op, operand_a, operand_b);
                mCnt <= W + 1;
            end else begin
                if (mthi) mHi <= hi_wdata;
                if (mtlo) mLo <= hi_wdata;
            end
        end
    end

    always @(negedge clk) begin
        if (chkEn) begin
            check("busy", busy, mCnt != 0);
            check("done", done, mDone);
            check("div_by_zero", div_by_zero, mDbz);
            check("hi", hi, mHi);
            check("lo", lo, mLo);
        end
    end

    // Caller is #1 after a rising edge; start is presented immediately so
    // chained calls also exercise acceptance in the done cycle.
    task automatic runOp(input logic [1:0] o, input logic [W-1:0] a, input logic [W-1:0] b,
                         input bit inject, input string name,
                         input logic [W-1:0] expHi, input logic [W-1:0] expLo, input bit expDbz,
                         output logic [W-1:0] loAfterStart);
        int lat, busyCycles;
        op = o; operand_a = a; operand_b = b; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; mthi = 1'b0; mtlo = 1'b0;
        loAfterStart = lo;
        lat = 0;
        busyCycles = busy ? 1 : 0;
        for (int n = 1; n <= 100; n++) begin
            if (inject && n == 5) begin
                start = 1'b1; op = OP_DIVU; mthi = 1'b1; mtlo = 1'b1; hi_wdata = 32'h1234;
            end
            @(posedge clk); #1;
            if (inject && n == 5) begin
                start = 1'b0; mthi = 1'b0; mtlo = 1'b0;
            end
            if (done) begin
                lat = n;
                break;
            end
            if (busy) busyCycles++;
        end
        check({name, " latency"}, lat, W + 1);
        check({name, " busy cycles"}, busyCycles, W + 1);
        check({name, " hi"}, hi, expHi);
        check({name, " lo"}, lo, expLo);
        check({name, " div_by_zero"}, div_by_zero, expDbz);
    endtask

    initial begin
        logic [W-1:0] loS;
        int doneSeen;
        repeat (3) @(posedge clk);
        #1;
        check("reset busy", busy, 1'b0);
        check("reset done", done, 1'b0);
        check("reset hi", hi, 32'h0);
        check("reset lo", lo, 32'h0);
        chkEn = 1'b1;
        reset = 1'b0;
        @(posedge clk); #1;

        runOp(OP_MULT,  32'hFFFF_FFFD, 32'd7,         1'b0, "mult -3*7",  32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b0, loS);
        runOp(OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, "multu max",  32'hFFFF_FFFE, 32'h0000_0001, 1'b0, loS);
        runOp(OP_MULT,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, "mult -1*-1", 32'h0,         32'h1,         1'b0, loS);
        runOp(OP_DIV,   32'hFFFF_FFF9, 32'd2,         1'b0, "div -7/2",   32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0, loS);
        runOp(OP_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 1'b0, "div min/-1", 32'h0,         32'h8000_0000, 1'b0, loS);
        runOp(OP_DIV,   32'd7,         32'hFFFF_FFFE, 1'b0, "div 7/-2",   32'h1,         32'hFFFF_FFFD, 1'b0, loS);
        runOp(OP_DIVU,  32'hFFFF_FFFF, 32'h10,        1'b0, "divu max/16", 32'hF,        32'h0FFF_FFFF, 1'b0, loS);
        runOp(OP_DIVU,  32'd100,       32'd0,         1'b0, "divu 100/0", 32'h64,        32'hFFFF_FFFF, 1'b1, loS);
        check("divu 100/0 done", done, 1'b1);
        @(posedge clk); #1;
        check("dbz one-cycle", div_by_zero, 1'b0);
        runOp(OP_DIV,   32'hFFFF_FFFB, 32'd0,         1'b0, "div -5/0",   32'hFFFF_FFFB, 32'hFFFF_FFFF, 1'b1, loS);

        runOp(OP_MULT, 32'd6, 32'd7, 1'b1, "mult gated", 32'h0, 32'd42, 1'b0, loS);
        mthi = 1'b1; hi_wdata = 32'h1234;
        @(posedge clk); #1;
        mthi = 1'b0;
        check("mthi hi", hi, 32'h1234);
        check("mthi lo", lo, 32'd42);

        mtlo = 1'b1; hi_wdata = 32'hBEEF;
        runOp(OP_MULTU, 32'd3, 32'd5, 1'b0, "start+mtlo", 32'h0, 32'd15, 1'b0, loS);
        check("mtlo dropped", loS, 32'd42);

        op = OP_DIV; operand_a = 32'd1000; operand_b = 32'd3; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (9) @(posedge clk);
        #1;
        reset = 1'b1;
        #1;
        check("midreset busy", busy, 1'b0);
        check("midreset done", done, 1'b0);
        check("midreset hi", hi, 32'h0);
        check("midreset lo", lo, 32'h0);
        @(posedge clk); #1;
        reset = 1'b0;
        doneSeen = 0;
        for (int n = 0; n < 40; n++) begin
            @(posedge clk); #1;
            if (done) doneSeen++;
        end
        check("no done after reset", doneSeen, 0);
        runOp(OP_MULT, 32'd6, 32'd7, 1'b0, "mult 6*7", 32'h0, 32'd42, 1'b0, loS);

        @(posedge clk); #1;
        chkEn = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/mult_div_unit.md
Name: mult_div_unit

Overview:
- Iterative multiply/divide unit owning the architectural HI/LO registers.
- Executes MULT, MULTU, DIV and DIVU on the two register-file read operands (rs, rt).
- Handles MTHI/MTLO writes and exposes hi/lo continuously, so the MFHI/MFLO path can select them onto the register-file write-data mux.
- Sits beside the ALU: downstream of the register-file read ports, upstream of its write port.

Parameters:
WIDTH, 32, operand/HI/LO width; the iteration count equals WIDTH.

Ports:
clk  input  1  rising-edge clock
reset  input  1  asynchronous, active-high reset
start  input  1  request an operation; sampled only when busy=0
op  input  2  00 MULT, 01 MULTU, 10 DIV, 11 DIVU; sampled with start
operand_a  input  WIDTH  rs value (multiplicand / dividend)
operand_b  input  WIDTH  rt value (multiplier / divisor)
mthi  input  1  write hi_wdata into HI
mtlo  input  1  write hi_wdata into LO
hi_wdata  input  WIDTH  data for MTHI/MTLO
busy  output  1  operation in progress
done  output  1  one-cycle pulse when HI/LO receive a result
div_by_zero  output  1  one-cycle pulse, coincident with done, for DIV/DIVU with operand_b=0
hi  output  WIDTH  HI register
lo  output  WIDTH  LO register

Behaviour:
- Reset (async, reset=1): state=IDLE; busy=0, done=0, div_by_zero=0, hi=0, lo=0; iteration counter=0. Applies mid-operation too: the operation is abandoned, no result is written, and no done pulse follows.

FSM states: IDLE, CALC, FIX.
- IDLE:
  - If start=1 at edge E0: latch op; latch operand magnitudes (absolute values for signed ops; unsigned values otherwise); latch the result sign and remainder sign; clear the accumulator; set counter=WIDTH; busy=1; go to CALC.
  - Otherwise, if mthi/mtlo=1: write HI/LO from hi_wdata at that edge. Both may be asserted together; both are written.
  - start has priority: in a cycle with both start and mthi/mtlo, the mthi/mtlo writes are dropped.
- CALC: one iteration per edge, E1..E_WIDTH; counter decrements; exits to FIX when the counter reaches 1 at the edge.
  - Multiply: shift-add, one multiplier bit per cycle, into a 2*WIDTH accumulator.
  - Divide: restoring division, one quotient bit per cycle; the partial remainder is WIDTH+1 bits.
- FIX, edge E_WIDTH+1:
  - Apply sign correction (two's-complement negation where required).
  - Write HI/LO; busy=0, done=1 (for exactly one cycle); go to IDLE.
- Latency:
  - done is high in the cycle after edge E_WIDTH+1, i.e. WIDTH+1 cycles after the start cycle (33 at WIDTH=32).
  - busy is high for WIDTH+1 cycles.
  - A new start is accepted in the same cycle that done is high.
- While busy=1, start, mthi and mtlo are ignored. hi/lo hold their previous values until the FIX edge.

Result rules:
- MULT/MULTU: {hi,lo} = full 2*WIDTH product, signed or unsigned respectively.
- DIV: lo = quotient truncated toward zero; hi = remainder, which takes the sign of the dividend.
- DIVU: unsigned quotient in lo, remainder in hi.
- Divide by zero (DIV or DIVU): lo = all ones, hi = operand_a unchanged; div_by_zero pulses with done; latency unchanged.
- DIV of 0x80000000 by 0xFFFFFFFF: lo = 0x80000000, hi = 0. No trap is taken.
- Magnitude 2^(WIDTH-1) must be held correctly as an unsigned value.

Test Plan:
- Product: MULT a=0xFFFFFFFD (-3), b=7 -> hi=0xFFFFFFFF, lo=0xFFFFFFEB; done exactly 33 cycles after start; busy high for 33 cycles.
- Unsigned product / signed edges: MULTU a=b=0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001. MULT of the same operands -> hi=0, lo=1.
- Signed division: DIV a=0xFFFFFFF9 (-7), b=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF. DIV 0x80000000 by 0xFFFFFFFF -> lo=0x80000000, hi=0.
- Divide by zero: DIVU a=100, b=0 -> lo=0xFFFFFFFF, hi=0x00000064; div_by_zero and done pulse together for one cycle.
- Busy gating and MTHI/MTLO:
  - During a MULT, pulse start (op=DIVU) and mthi with hi_wdata=0x1234 -> both ignored; the MULT result is unaffected.
  - After done, mthi with 0x1234 -> hi=0x1234 next cycle, lo unchanged.
  - start+mtlo in the same IDLE cycle -> mtlo dropped.
- Reset mid-operation: assert reset at cycle 10 of a DIV -> busy/done/hi/lo=0 immediately. No done pulse follows. A fresh MULT 6*7 after release gives lo=42, hi=0.
